// File: rtl/light_pkg.sv
// rtl/light_pkg.sv - states, phase tables and light encodings for the light sequencer
package light_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_RED_ISSUE,
        ST_RED_WAIT,
        ST_RY_ISSUE,
        ST_RY_WAIT,
        ST_GREEN_ISSUE,
        ST_GREEN_WAIT,
        ST_YEL_ISSUE,
        ST_YEL_WAIT,
        ST_FAULT
    } state_e;

    typedef enum logic [1:0] {
        PH_RED,
        PH_RED_YEL,
        PH_GREEN,
        PH_YELLOW
    } phase_e;

    localparam logic [2:0] LIGHT_RED     = 3'b100;
    localparam logic [2:0] LIGHT_RED_YEL = 3'b110;
    localparam logic [2:0] LIGHT_GREEN   = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW  = 3'b010;

    // bit p set: phase p uses the long interval
    localparam logic [3:0] PHASE_IS_LONG = 4'b0101;

    function automatic phase_e phase_of(state_e s);
        case (s)
            ST_RY_ISSUE, ST_RY_WAIT:       return PH_RED_YEL;
            ST_GREEN_ISSUE, ST_GREEN_WAIT: return PH_GREEN;
            ST_YEL_ISSUE, ST_YEL_WAIT:     return PH_YELLOW;
            default:                       return PH_RED;
        endcase
    endfunction

    function automatic logic is_issue(state_e s);
        return s inside {ST_RED_ISSUE, ST_RY_ISSUE, ST_GREEN_ISSUE, ST_YEL_ISSUE};
    endfunction

    function automatic logic is_wait(state_e s);
        return s inside {ST_RED_WAIT, ST_RY_WAIT, ST_GREEN_WAIT, ST_YEL_WAIT};
    endfunction

    function automatic state_e issue_of(phase_e p);
        case (p)
            PH_RED_YEL: return ST_RY_ISSUE;
            PH_GREEN:   return ST_GREEN_ISSUE;
            PH_YELLOW:  return ST_YEL_ISSUE;
            default:    return ST_RED_ISSUE;
        endcase
    endfunction

    function automatic state_e wait_of(phase_e p);
        case (p)
            PH_RED_YEL: return ST_RY_WAIT;
            PH_GREEN:   return ST_GREEN_WAIT;
            PH_YELLOW:  return ST_YEL_WAIT;
            default:    return ST_RED_WAIT;
        endcase
    endfunction

    function automatic phase_e next_phase(phase_e p);
        case (p)
            PH_RED:     return PH_RED_YEL;
            PH_RED_YEL: return PH_GREEN;
            PH_GREEN:   return PH_YELLOW;
            default:    return PH_RED;
        endcase
    endfunction

    function automatic logic [2:0] light_of(phase_e p);
        case (p)
            PH_RED_YEL: return LIGHT_RED_YEL;
            PH_GREEN:   return LIGHT_GREEN;
            PH_YELLOW:  return LIGHT_YELLOW;
            default:    return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// rtl/light_sequencer_if.sv - trigger/done handshake between sequencer and interval counter
interface light_sequencer_if;
    logic trL;
    logic trS;
    logic tL;
    logic tS;

    modport master (output trL, output trS, input tL, input tS);
    modport slave  (input trL, input trS, output tL, output tS);
endinterface

// File: rtl/lseq_wdog.sv
// rtl/lseq_wdog.sv - clear/enable saturating counter, flags the LIMIT-th enabled cycle
module lseq_wdog #(
    parameter int W     = 7,
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] SAT  = W'(LIMIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != SAT) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/light_sequencer.sv
// rtl/light_sequencer.sv - traffic light phase FSM with counter watchdog and pedestrian latch
module light_sequencer
    import light_pkg::*;
#(
    parameter int WDOG_CYCLES = 64,
    parameter int FLASH_DIV   = 8,
    parameter int WDOG_W      = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    light_sequencer_if.master ctr,
    input  logic              ped_btn,
    output logic [2:0]        light,
    output logic              walk,
    output logic              fault
);
    state_e     state_q, state_d;
    logic [2:0] light_q, light_d;
    logic       trl_q, trl_d;
    logic       trs_q, trs_d;
    logic       walk_q, walk_d;
    logic       fault_q, fault_d;
    logic       ped_q, ped_d;

    phase_e     cur_ph, nxt_ph;
    logic       long_ph, done_match, done_wrong, enter_red;
    logic       wd_en, wd_hit, fl_en, fl_clr, fl_hit;

    assign wd_en  = is_wait(state_q);
    assign fl_en  = (state_q == ST_FAULT);
    assign fl_clr = !fl_en || fl_hit;

    lseq_wdog #(.W(WDOG_W), .LIMIT(WDOG_CYCLES)) u_wdog (
        .clk(clk), .reset_n(reset_n), .clr_i(!wd_en), .en_i(wd_en), .hit_o(wd_hit)
    );

    lseq_wdog #(.W(WDOG_W), .LIMIT(FLASH_DIV)) u_flash (
        .clk(clk), .reset_n(reset_n), .clr_i(fl_clr), .en_i(fl_en), .hit_o(fl_hit)
    );

    always_comb begin
        state_d    = state_q;
        cur_ph     = phase_of(state_q);
        long_ph    = PHASE_IS_LONG[cur_ph];
        done_match = long_ph ? ctr.tL : ctr.tS;
        // tL and tS together always includes the wrong one
        done_wrong = long_ph ? ctr.tS : ctr.tL;

        if (state_q == ST_INIT) begin
            state_d = ST_RED_ISSUE;
        end else if (is_issue(state_q)) begin
            state_d = wait_of(cur_ph);
        end else if (is_wait(state_q)) begin
            if (done_wrong || wd_hit) begin
                state_d = ST_FAULT;
            end else if (done_match) begin
                state_d = issue_of(next_phase(cur_ph));
            end
        end

        nxt_ph    = phase_of(state_d);
        fault_d   = (state_d == ST_FAULT);
        trl_d     = is_issue(state_d) && PHASE_IS_LONG[nxt_ph];
        trs_d     = is_issue(state_d) && !PHASE_IS_LONG[nxt_ph];
        enter_red = (state_d == ST_RED_ISSUE);

        if (!fault_d) begin
            light_d = light_of(nxt_ph);
        end else if (state_q != ST_FAULT) begin
            light_d = LIGHT_YELLOW;
        end else if (fl_hit) begin
            light_d = light_q ^ LIGHT_YELLOW;
        end else begin
            light_d = light_q;
        end

        ped_d  = ped_q;
        walk_d = walk_q;
        if (state_q != ST_FAULT) begin
            ped_d = enter_red ? ped_btn : (ped_q | ped_btn);
        end
        if (enter_red) begin
            walk_d = ped_q;
        end
        if (state_d == ST_RY_ISSUE || fault_d) begin
            walk_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            light_q <= LIGHT_RED;
            trl_q   <= 1'b0;
            trs_q   <= 1'b0;
            walk_q  <= 1'b0;
            fault_q <= 1'b0;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            light_q <= light_d;
            trl_q   <= trl_d;
            trs_q   <= trs_d;
            walk_q  <= walk_d;
            fault_q <= fault_d;
            ped_q   <= ped_d;
        end
    end

    assign ctr.trL = trl_q;
    assign ctr.trS = trs_q;
    assign light   = light_q;
    assign walk    = walk_q;
    assign fault   = fault_q;
endmodule

// File: tb/tb_light_sequencer.sv
// tb/tb_light_sequencer.sv - randomized self-checking bench against a phase-timeline model
module tb_light_sequencer;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       ped_btn;
    logic [2:0] light;
    logic       walk;
    logic       fault;
    int         n_checks = 0;
    int         n_fail = 0;

    light_sequencer_if cif();

    light_sequencer #(.WDOG_CYCLES(64), .FLASH_DIV(8), .WDOG_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .ctr(cif), .ped_btn(ped_btn),
        .light(light), .walk(walk), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] exp_light(int p);
        case (p)
            0: return 3'b100;
            1: return 3'b110;
            2: return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic s, input logic p);
        cif.tL  = l;
        cif.tS  = s;
        ped_btn = p;
    endtask

    task automatic do_reset();
        drive(0, 0, 0);
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    // Called in the INIT cycle. Phase k starts at start[k]; counter answers after lat cycles.
    task automatic run_normal(input int lat_l, input int lat_s, input int nph, input int pmode,
                              input bit spur, input int mute_from, input string tag);
        int         start[0:32];
        bit         press[0:4095];
        bit         wv[0:31];
        int         k, pend, w, last;
        bit         kind_l;
        logic [6:0] e, o;
        start[0] = 1;
        for (int j = 0; j < nph; j++)
            start[j+1] = start[j] + ((j % 2 == 0) ? lat_l : lat_s) + 1;
        last = start[nph] - 1;
        for (int t = 0; t <= last; t++)
            press[t] = (pmode == 2) ? ($urandom_range(0, 7) == 0) : (pmode == 1 && t == start[2] + 1);
        k = 0; pend = 0; w = 0; kind_l = 0;
        drive(0, 0, press[0]);
        for (int t = 1; t <= last; t++) begin
            step();
            while (k + 1 < nph && start[k+1] <= t) k++;
            if (k % 4 == 0 && t == start[k]) begin
                wv[k] = 1'b0;
                for (int j = w; j <= t - 2; j++) wv[k] |= press[j];
                w = t - 1;
            end
            e = {exp_light(k % 4), (t == start[k]) && (k % 2 == 0), (t == start[k]) && (k % 2 == 1),
                 (k % 4 == 0) ? wv[k] : 1'b0, 1'b0};
            o = {light, cif.trL, cif.trS, walk, fault};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s cycle %0d {light,trL,trS,walk,fault} got %b exp %b", tag, t, o, e);
            end
            cif.tL = 1'b0;
            cif.tS = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (kind_l) cif.tL = 1'b1;
                    else        cif.tS = 1'b1;
                end
            end
            if (k < mute_from && cif.trL === 1'b1) begin
                pend = lat_l; kind_l = 1'b1;
            end else if (k < mute_from && cif.trS === 1'b1) begin
                pend = lat_s; kind_l = 1'b0;
            end
            if (spur && t == start[k]) begin
                cif.tL = 1'($urandom_range(0, 1));
                cif.tS = 1'($urandom_range(0, 1));
            end
            ped_btn = press[t];
        end
    endtask

    // Called in the first cycle where fault should be visible.
    task automatic check_fault(input int n, input string tag);
        logic [6:0] e, o;
        for (int i = 0; i < n; i++) begin
            e = {((i / 8) % 2 == 0) ? 3'b010 : 3'b000, 4'b0001};
            o = {light, cif.trL, cif.trS, walk, fault};
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s fault cycle %0d {light,trL,trS,walk,fault} got %b exp %b", tag, i, o, e);
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        drive(0, 0, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        n_checks++;
        if ({light, cif.trL, cif.trS, walk, fault} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL %s got %b exp %b", tag, {light, cif.trL, cif.trS, walk, fault}, 7'b1000000);
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0);
        reset_n = 1'b0;
        step();
        check_reset_vals("reset_values");
        drive(1, 1, 1);
        repeat (3) begin
            step();
            check_reset_vals("reset_held_inputs_active");
        end
        drive(0, 0, 0);
        reset_n = 1'b1;
        check_reset_vals("init_cycle");
        step();
        n_checks++;
        if ({light, cif.trL, cif.trS} !== 5'b10010) begin
            n_fail++;
            $display("FAIL init_to_red_issue got %b exp %b", {light, cif.trL, cif.trS}, 5'b10010);
        end
    endtask

    task automatic test_sequence();
        do_reset();
        run_normal(2, 4, 5, 0, 0, 99, "seq_ideal");
        repeat (3) begin
            do_reset();
            run_normal($urandom_range(1, 12), $urandom_range(1, 12), 9, 2, 0, 99, "seq_random");
        end
        do_reset();
        run_normal(61, 60, 5, 0, 0, 99, "seq_longest");
    endtask

    task automatic test_ped();
        do_reset();
        run_normal(2, 4, 9, 1, 0, 99, "ped_green_wait");
    endtask

    task automatic test_wrong_done();
        do_reset();
        step();
        step();
        n_checks++;
        if ({light, cif.trL, cif.trS, fault} !== 6'b100000) begin
            n_fail++;
            $display("FAIL red_wait_pre got %b exp %b", {light, cif.trL, cif.trS, fault}, 6'b100000);
        end
        cif.tS = 1'b1;
        step();
        cif.tS = 1'b0;
        check_fault(40, "wrong_done");
    endtask

    task automatic test_watchdog();
        int g;
        g = 1 + (2 + 1) + (4 + 1);
        do_reset();
        run_normal(2, 4, 3, 0, 0, 2, "wdog_pre");
        for (int c = g + 3; c <= g + 64; c++) begin
            step();
            n_checks++;
            if ({light, cif.trL, cif.trS, fault} !== 6'b001000) begin
                n_fail++;
                $display("FAIL wdog_wait cycle %0d got %b exp %b", c, {light, cif.trL, cif.trS, fault}, 6'b001000);
            end
        end
        step();
        check_fault(20, "wdog_expired");
    endtask

    task automatic test_both_done();
        do_reset();
        run_normal(2, 4, 4, 0, 0, 3, "both_pre");
        drive(1, 1, 0);
        step();
        drive(0, 0, 0);
        check_fault(20, "both_done");
    endtask

    task automatic test_spurious();
        repeat (2) begin
            do_reset();
            run_normal($urandom_range(1, 10), $urandom_range(1, 10), 9, 2, 1, 99, "spurious");
        end
    endtask

    task automatic test_reset_recovery();
        do_reset();
        run_normal(2, 4, 3, 1, 0, 2, "mid_green_pre");
        reset_n = 1'b0;
        drive(0, 0, 0);
        step();
        check_reset_vals("mid_green_reset");
        reset_n = 1'b1;
        run_normal(2, 4, 6, 0, 0, 99, "mid_green_post");
        do_reset();
        step();
        step();
        cif.tS = 1'b1;
        step();
        cif.tS = 1'b0;
        n_checks++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_before_reset got %b exp %b", fault, 1'b1);
        end
        reset_n = 1'b0;
        step();
        check_reset_vals("fault_reset");
        reset_n = 1'b1;
        run_normal(3, 5, 5, 2, 0, 99, "fault_post");
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0);
        test_reset();
        test_sequence();
        test_ped();
        test_wrong_done();
        test_watchdog();
        test_both_done();
        test_spurious();
        test_reset_recovery();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
